// File: rtl/eth_rx_slot_writer.sv
// MAC receive byte stream -> 16-bit frame-buffer port, split into NUM_SLOTS frame slots.
// Tracks per-slot full/length for the reader; oversize, errored and no-room frames are counted as drops.
module eth_rx_slot_writer #(
   parameter  int ADDR_W    = 11,
   parameter  int SLOT_LOG2 = 1,
   parameter  int MAX_LEN   = 1536,
   localparam int NUM_SLOTS = 1 << SLOT_LOG2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   input  logic                    rx_sof,
   input  logic                    rx_eof,
   input  logic                    rx_err,
   output logic                    mem_en,
   output logic [1:0]              mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [15:0]             mem_din,
   input  logic [NUM_SLOTS-1:0]    slot_release,
   output logic [NUM_SLOTS-1:0]    slot_full,
   output logic [NUM_SLOTS*12-1:0] slot_len,
   output logic [SLOT_LOG2-1:0]    wr_slot,
   output logic [15:0]             drop_cnt
);

   localparam int OFS_W = ADDR_W - SLOT_LOG2;

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t                      state_q, state_d;
   logic [11:0]                 cnt_q, cnt_d, cur_cnt;
   logic                        mem_en_q, mem_en_d;
   logic [1:0]                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
   logic [15:0]                 mem_din_q, mem_din_d;
   logic [NUM_SLOTS-1:0]        slot_full_q, slot_full_d;
   logic [NUM_SLOTS-1:0][11:0]  slot_len_q, slot_len_d;
   logic [SLOT_LOG2-1:0]        wr_slot_q, wr_slot_d;
   logic [15:0]                 drop_cnt_q, drop_cnt_d;
   logic                        start, take, drop_inc;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 2'b00;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      slot_full_d = slot_full_q & ~slot_release;
      slot_len_d  = slot_len_q;
      wr_slot_d   = wr_slot_q;
      drop_inc    = 1'b0;
      start       = rx_valid & rx_sof;
      cur_cnt     = start ? 12'd0 : cnt_q;
      // A sof always restarts at the slot base, whatever state we were in.
      take        = rx_valid & (start ? ~slot_full_q[wr_slot_q] : (state_q == RECV));

      if (take) begin
         if (cur_cnt == 12'(MAX_LEN)) begin
            state_d  = rx_eof ? IDLE : DROP;
            drop_inc = rx_eof;
         end else begin
            mem_en_d   = 1'b1;
            mem_we_d   = cur_cnt[0] ? 2'b10 : 2'b01;
            mem_addr_d = {wr_slot_q, cur_cnt[OFS_W:1]};
            mem_din_d  = {rx_data, rx_data};
            cnt_d      = cur_cnt + 12'd1;
            state_d    = RECV;
            if (rx_eof) begin
               state_d = IDLE;
               if (rx_err) begin
                  drop_inc = 1'b1;
               end else begin
                  // Set after the release mask so completion wins over a same-cycle release.
                  slot_full_d[wr_slot_q] = 1'b1;
                  slot_len_d[wr_slot_q]  = cur_cnt + 12'd1;
                  wr_slot_d              = wr_slot_q + SLOT_LOG2'(1);
               end
            end
         end
      end else if (rx_valid & (start | (state_q == DROP))) begin
         state_d  = rx_eof ? IDLE : DROP;
         drop_inc = rx_eof;
      end

      drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= '0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         slot_full_q <= '0;
         slot_len_q  <= '0;
         wr_slot_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         slot_full_q <= slot_full_d;
         slot_len_q  <= slot_len_d;
         wr_slot_q   <= wr_slot_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign slot_full = slot_full_q;
   assign slot_len  = slot_len_q;
   assign wr_slot   = wr_slot_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_slot_writer.sv
// Directed bench for eth_rx_slot_writer: per-beat vector table for a short frame,
// then frame-level sequences for slot exhaustion, oversize, errors, restarts and reset.
module tb_eth_rx_slot_writer;

   logic        clk, rstn;
   logic        rx_valid, rx_sof, rx_eof, rx_err;
   logic [7:0]  rx_data;
   logic        mem_en;
   logic [1:0]  mem_we;
   logic [10:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  slot_release, slot_full;
   logic [23:0] slot_len;
   logic [0:0]  wr_slot;
   logic [15:0] drop_cnt;

   int n_chk = 0;
   int n_pass = 0;

   logic [10:0] wa_q[$];
   logic [1:0]  we_q[$];

   eth_rx_slot_writer dut (
      .clk(clk), .rstn(rstn),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .slot_release(slot_release), .slot_full(slot_full), .slot_len(slot_len),
      .wr_slot(wr_slot), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every buffer write, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_en) begin
         wa_q.push_back(mem_addr);
         we_q.push_back(mem_we);
      end
   end

   typedef struct {
      logic        v, sof, eof;
      logic [7:0]  d;
      logic        en;
      logic [1:0]  we;
      logic [10:0] addr;
      logic [15:0] din;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic send_frame(input int len, input bit err, input bit with_eof);
      for (int i = 0; i < len; i++) begin
         rx_valid = 1'b1;
         rx_sof   = (i == 0);
         rx_eof   = with_eof && (i == len - 1);
         rx_err   = err && with_eof && (i == len - 1);
         rx_data  = 8'(i + 1);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_slots(input logic [1:0] m);
      slot_release = m;
      @(posedge clk); #1;
      slot_release = 2'b00;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic clear_log();
      wa_q.delete();
      we_q.delete();
   endtask

   initial begin
      rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_err = 0; rx_data = 0;
      slot_release = 0; rstn = 0;

      vecs[0] = '{1, 1, 0, 8'h11, 1, 2'b01, 11'd0, 16'h1111};
      vecs[1] = '{1, 0, 0, 8'h22, 1, 2'b10, 11'd0, 16'h2222};
      vecs[2] = '{1, 0, 0, 8'h33, 1, 2'b01, 11'd1, 16'h3333};
      vecs[3] = '{1, 0, 0, 8'h44, 1, 2'b10, 11'd1, 16'h4444};
      vecs[4] = '{1, 0, 1, 8'h55, 1, 2'b01, 11'd2, 16'h5555};
      vecs[5] = '{0, 0, 0, 8'h00, 0, 2'b00, 11'd0, 16'h0000};
      vecs[6] = '{1, 0, 0, 8'h66, 0, 2'b00, 11'd0, 16'h0000}; // no sof in IDLE: ignored

      // Reset state
      do_reset();
      chk("reset_mem", 32'({mem_en, mem_we, mem_addr, mem_din}), 32'd0);
      chk("reset_status", 32'({slot_full, wr_slot}), 32'd0);
      chk("reset_len", 32'(slot_len), 32'd0);
      chk("reset_drop", 32'(drop_cnt), 32'd0);

      // 5-byte frame, beat by beat
      for (int i = 0; i < 7; i++) begin
         rx_valid = vecs[i].v; rx_sof = vecs[i].sof; rx_eof = vecs[i].eof;
         rx_err = 1'b0; rx_data = vecs[i].d;
         @(posedge clk); #1;
         if (vecs[i].en)
            chk($sformatf("vec%0d_write", i), 32'({mem_en, mem_we, mem_addr, mem_din}),
                32'({vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din}));
         else
            chk($sformatf("vec%0d_idle", i), 32'({mem_en, mem_we}), 32'd0);
      end
      rx_valid = 0;
      settle();
      chk("f5_full", 32'(slot_full), 32'b01);
      chk("f5_len0", 32'(slot_len[11:0]), 32'd5);
      chk("f5_wr_slot", 32'(wr_slot), 32'd1);

      // Fill both slots, then a no-room drop
      do_reset();
      clear_log();
      send_frame(64, 0, 1);
      send_frame(60, 0, 1);
      settle();
      chk("fill_writes", 32'(wa_q.size()), 32'd124);
      chk("fill_slot1_base", 32'(wa_q[64]), 32'd1024);
      chk("fill_full", 32'(slot_full), 32'b11);
      chk("fill_lens", 32'(slot_len), 32'({12'd60, 12'd64}));
      clear_log();
      send_frame(100, 0, 1);
      settle();
      chk("noroom_writes", 32'(wa_q.size()), 32'd0);
      chk("noroom_drop", 32'(drop_cnt), 32'd1);
      chk("noroom_full", 32'(slot_full), 32'b11);

      release_slots(2'b01);
      chk("release_full", 32'(slot_full), 32'b10);
      chk("release_len_held", 32'(slot_len[11:0]), 32'd64);
      clear_log();
      send_frame(32, 0, 1);
      settle();
      chk("f4_writes", 32'(wa_q.size()), 32'd32);
      chk("f4_base", 32'({wa_q[0], we_q[0]}), 32'({11'd0, 2'b01}));
      chk("f4_full", 32'({slot_full, wr_slot}), 32'({2'b11, 1'b1}));
      chk("f4_len0", 32'(slot_len[11:0]), 32'd32);

      // Oversize frame then a maximum-length frame in slot 1
      release_slots(2'b11);
      clear_log();
      send_frame(1537, 0, 1);
      settle();
      chk("over_writes", 32'(wa_q.size()), 32'd1536);
      chk("over_last", 32'({wa_q[1535], we_q[1535]}), 32'({11'd1791, 2'b10}));
      chk("over_status", 32'({slot_full, wr_slot}), 32'({2'b00, 1'b1}));
      chk("over_drop", 32'(drop_cnt), 32'd2);
      clear_log();
      send_frame(1536, 0, 1);
      settle();
      chk("max_writes", 32'(wa_q.size()), 32'd1536);
      chk("max_len1", 32'(slot_len[23:12]), 32'd1536);
      chk("max_status", 32'({slot_full, wr_slot}), 32'({2'b10, 1'b0}));

      // Errored frame: written but not committed
      clear_log();
      send_frame(8, 1, 1);
      settle();
      chk("err_writes", 32'(wa_q.size()), 32'd8);
      chk("err_status", 32'({slot_full, wr_slot}), 32'({2'b10, 1'b0}));
      chk("err_drop", 32'(drop_cnt), 32'd3);

      // Missing eof: 10 bytes, then a 20-byte frame back to back
      clear_log();
      send_frame(10, 0, 0);
      send_frame(20, 0, 1);
      settle();
      chk("restart_writes", 32'(wa_q.size()), 32'd30);
      chk("restart_base", 32'({wa_q[10], we_q[10]}), 32'({11'd0, 2'b01}));
      chk("restart_len0", 32'(slot_len[11:0]), 32'd20);
      chk("restart_drop", 32'(drop_cnt), 32'd3);
      chk("restart_status", 32'({slot_full, wr_slot}), 32'({2'b11, 1'b1}));

      // One-cycle reset mid-frame, then a single-byte frame
      send_frame(5, 0, 0);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("midrst_mem", 32'({mem_en, mem_we, mem_addr, mem_din}), 32'd0);
      chk("midrst_status", 32'({slot_full, wr_slot, drop_cnt}), 32'd0);
      chk("midrst_len", 32'(slot_len), 32'd0);
      clear_log();
      send_frame(1, 0, 1);
      settle();
      chk("one_byte_write", 32'({wa_q.size(), we_q[0]}), 32'({30'd1, 2'b01}));
      chk("one_byte_len0", 32'(slot_len[11:0]), 32'd1);
      chk("one_byte_status", 32'({slot_full, wr_slot}), 32'({2'b01, 1'b1}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/eth_rx_slot_writer.md
Name: eth_rx_slot_writer

Overview:
- Receive-side writer that sits directly upstream of the 16-bit port of the dual-port frame buffer.
- Takes the MAC receive byte stream, writes each byte into the buffer through byte-lane enables, and splits the buffer into NUM_SLOTS frame slots.
- Tracks per-slot full/length status for the CPU-side reader, which consumes frames over the 64-bit port and releases slots.
- Oversize, errored and no-room frames are discarded and counted.

Parameters:
- ADDR_W, 11, word address width of the 16-bit buffer port (2^ADDR_W x 16-bit words).
- SLOT_LOG2, 1, log2 of slot count; NUM_SLOTS = 2^SLOT_LOG2; slot size = 2^(ADDR_W+1-SLOT_LOG2) bytes.
- MAX_LEN, 1536, maximum accepted frame length in bytes; must be <= slot size.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  synchronous active-low reset.
- rx_valid  in  1  byte strobe from MAC.
- rx_data  in  8  received byte.
- rx_sof  in  1  first byte of frame; qualified by rx_valid.
- rx_eof  in  1  last byte of frame; qualified by rx_valid.
- rx_err  in  1  frame error flag; sampled with rx_eof.
- mem_en  out  1  buffer port enable.
- mem_we  out  2  byte write enables; [0] = low lane, [1] = high lane.
- mem_addr  out  ADDR_W  buffer word address.
- mem_din  out  16  write data.
- slot_release  in  NUM_SLOTS  one-cycle pulse per slot; frees that slot.
- slot_full  out  NUM_SLOTS  slot holds a complete, good frame.
- slot_len  out  NUM_SLOTS*12  byte length per slot; slot s at bits [12s+11:12s].
- wr_slot  out  SLOT_LOG2  slot the next or current frame is written into.
- drop_cnt  out  16  count of discarded frames; saturates at 0xFFFF.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state IDLE; mem_en, mem_we, mem_addr, mem_din = 0.
  - slot_full = 0, slot_len = 0, wr_slot = 0, drop_cnt = 0, byte counter = 0.
  - Reset mid-frame abandons the frame; no status update.
- States:
  - IDLE: waits for rx_valid & rx_sof.
  - RECV: bytes are being written.
  - DROP: discarding until eof.
- IDLE -> RECV on rx_valid & rx_sof when slot_full[wr_slot] = 0; otherwise IDLE -> DROP.
- Write path, one registered stage:
  - Accepted byte at cycle N produces mem_en = 1 at cycle N+1.
  - mem_din = {b,b}; mem_addr = {wr_slot, cnt[ADDR_W-SLOT_LOG2:1]}.
  - mem_we = 2'b01 if cnt[0] = 0, else 2'b10. cnt is the byte offset within the frame, starting at 0 on sof.
  - mem_en and mem_we are 0 in every cycle without a written byte.
- Length: len = number of bytes including the eof byte.
  - Byte with cnt = MAX_LEN (the MAX_LEN+1-th byte) is not written; state -> DROP.
  - An eof on that same byte still counts as a drop.
- rx_eof in RECV:
  - rx_err = 0: the eof byte is written. One cycle after the eof byte (same cycle as its memory write), slot_full[wr_slot] <= 1, slot_len[wr_slot] <= len, and wr_slot increments modulo NUM_SLOTS. State -> IDLE.
  - rx_err = 1: the byte is written, but no status change and wr_slot is unchanged; drop_cnt increments; state -> IDLE.
- DROP: no writes. On rx_valid & rx_eof, drop_cnt increments and state -> IDLE.
- sof & eof on the same byte: single-byte frame, handled as sof then eof in one beat (len = 1).
- rx_sof while in RECV (missing eof): current frame is abandoned without status update or drop count; restart at cnt = 0 in the same slot.
- rx_sof while in DROP: treated as a new frame start with the IDLE rules.
- rx_valid with no sof in IDLE: ignored.
- slot_release[s]: clears slot_full[s] next cycle; slot_len[s] is held. Releasing a non-full slot has no effect.
- Simultaneous release and frame completion on the same slot: completion wins (full stays 1, new length).
- Back-to-back frames (eof byte followed immediately by sof byte) are fully supported; no idle cycle is required.

Test Plan:
- Reset, then a 5-byte frame 0x11..0x55 -> 5 writes:
  - addr 0 we 01, addr 0 we 10, addr 1 we 01, addr 1 we 10, addr 2 we 01.
  - Then slot_full = 01, slot_len[0] = 5, wr_slot = 1.
- Two good frames (64 B, 60 B) with no release -> slot_full = 11; third frame of 100 B -> no writes, drop_cnt = 1.
- Then pulse slot_release[0] -> fourth frame is written at base address 0, slot_full = 11.
- 1537-byte frame -> exactly 1536 writes, slot_full unchanged, drop_cnt + 1. A following 1536-byte frame is accepted with len 1536.
- Frame with rx_err on eof -> writes occur, slot_full unchanged, wr_slot unchanged, drop_cnt + 1.
- sof mid-frame after 10 bytes, then a 20-byte frame -> the second frame starts at the slot base; slot_len = 20, drop_cnt unchanged.
- rstn low for one cycle mid-frame -> all outputs 0. A subsequent 1-byte frame with sof & eof in one beat -> slot_len[0] = 1.
